flash_stream_player: RTL and testbench
======================================

Name: flash_stream_player

Overview:
Parametrised flash-to-audio streamer for the MP3 player datapath. It is an Avalon-MM read master that fetches packed sample words from flash between programmable start and end word addresses, forward or reverse. Words are buffered in a small prefetch FIFO to hide flash latency. Samples of configurable width are emitted at a programmable rate, with loop, done and underrun reporting, all on a single clock.

Parameters:
ADDR_W, 23, flash word address width
DATA_W, 32, flash read data width
SAMPLE_W, 8, audio sample width; must divide DATA_W (8 or 16 supported)
DIV_W, 16, sample-rate divider width
FIFO_DEPTH, 4, prefetch FIFO depth in words; power of two, at least 2

Ports:
clk  in  1  single system clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
enable  in  1  level; high = play, low = abort/stop
reverse  in  1  direction, latched at start: 1 = end_addr down to start_addr
loop  in  1  latched at start: 1 = wrap at bound instead of finishing
start_addr  in  ADDR_W  first word address (inclusive), latched at start
end_addr  in  ADDR_W  last word address (inclusive), latched at start
rate_count  in  DIV_W  sample period = rate_count+1 clk cycles; read live
flash_mem_waitrequest  in  1  Avalon slave stall
flash_mem_readdata  in  DATA_W  Avalon read data
flash_mem_readdatavalid  in  1  Avalon read data qualifier
flash_mem_read  out  1  Avalon read request
flash_mem_address  out  ADDR_W  Avalon word address
audio_out  out  SAMPLE_W  current sample, held between strobes
sample_strobe  out  1  1-cycle pulse when audio_out updates
playing  out  1  high from start until done or abort
done  out  1  1-cycle pulse at end of a non-loop pass
underrun  out  1  1-cycle pulse on a sample tick with the FIFO empty

Behaviour:
- Reset (reset=0, async): FSM IDLE, FIFO empty, divider 0. All outputs 0: flash_mem_read, flash_mem_address, audio_out, sample_strobe, playing, done, underrun.
- LANES = DATA_W/SAMPLE_W. Forward: lane 0 (bits SAMPLE_W-1:0) first, then ascending. Reverse: lane LANES-1 first, then descending.
- FSM states: IDLE, ISSUE, WAIT_DATA, DRAIN.
- IDLE -> ISSUE when enable=1 and armed. On this transition: latch reverse, loop, start_addr, end_addr; fetch pointer = start_addr (forward) or end_addr (reverse); playing=1; divider cleared.
- Arming: "armed" clears after done and sets again when enable=0 is seen. Holding enable high does not replay.
- start_addr > end_addr at start: no reads issued; done pulses the next cycle; playing stays 0.
- ISSUE: entered only when FIFO occupancy < FIFO_DEPTH, so one slot is free for the outstanding word.
  - flash_mem_read=1; flash_mem_address = fetch pointer.
  - Both are held stable while waitrequest=1.
  - On the cycle with read=1 and waitrequest=0: deassert read, go WAIT_DATA.
- WAIT_DATA: the cycle readdatavalid=1, push readdata into the FIFO and advance the fetch pointer (+1 forward, -1 reverse).
  - Fetch pointer passed the bound and loop=1: pointer wraps to the opposite bound; go ISSUE when the FIFO has space.
  - Fetch pointer passed the bound and loop=0: go DRAIN.
  - Otherwise: go ISSUE when the FIFO has space.
- Only one read is outstanding at a time.
- Sample tick: divider counts 0..rate_count while playing=1; a tick occurs on the wrap. rate_count=0 gives a tick every cycle.
- On a tick with the FIFO non-empty:
  - audio_out = current lane of the FIFO head; sample_strobe=1 the same cycle audio_out changes.
  - Lane advances; after the last lane the head word is popped.
- On a tick with the FIFO empty: underrun=1; audio_out held; lane unchanged.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- DRAIN: no reads. When the FIFO is empty after the final pop: done=1 for one cycle, playing=0, go IDLE; audio_out holds the last sample.
- Abort (enable=0 while playing):
  - playing=0 next cycle; FIFO flushed; audio_out=0; no more strobes.
  - If a read is accepted but its data is pending, its readdatavalid is absorbed in WAIT_DATA and discarded before IDLE.
  - If in ISSUE with waitrequest=1, read is held until accepted, then the data is discarded the same way.
  - No new read is issued after abort.
- Latency: first sample_strobe occurs at the first tick after the first word is pushed. Ticks before that pulse underrun.

Test Plan:
- Forward, SAMPLE_W=8, start=0x10, end=0x11, loop=0, rate_count=3. Words 0x44332211 and 0x88776655 with 2-cycle read latency -> audio_out 11,22,33,44,55,66,77,88, one strobe every 4 clks; exactly one done; 2 reads total.
- Same stimulus with reverse=1 -> addresses 0x11 then 0x10; samples 88,77,66,55,44,33,22,11.
- loop=1, start=end=0x5 -> repeated reads of 0x5; samples cycle the 4 lanes continuously; done never pulses.
- waitrequest held high for 10 cycles, rate_count=0 -> read and address stable throughout; underrun pulses on every tick until the first push; no sample lost.
- Abort with enable=0 while a read is outstanding -> the late readdatavalid is discarded; audio_out=0; playing=0; re-enable replays from start_addr.
- SAMPLE_W=16, start=0x20 > end=0x1F -> no flash_mem_read; done pulses once; playing stays 0.

Source files
------------

// File: rtl/flash_stream_player_if.sv
// Avalon-MM read channel between the flash stream player (master) and the flash controller (slave).
interface flash_stream_player_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic              flash_mem_waitrequest;
    logic [DATA_W-1:0] flash_mem_readdata;
    logic              flash_mem_readdatavalid;

    modport master (
        output flash_mem_read,
        output flash_mem_address,
        input  flash_mem_waitrequest,
        input  flash_mem_readdata,
        input  flash_mem_readdatavalid
    );

    modport slave (
        input  flash_mem_read,
        input  flash_mem_address,
        output flash_mem_waitrequest,
        output flash_mem_readdata,
        output flash_mem_readdatavalid
    );
endinterface

// File: rtl/flash_stream_player.sv
// Streams packed audio samples from flash between two word addresses, forward or reverse,
// through a small prefetch FIFO, emitting one sample per programmable rate tick.
module flash_stream_player #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int SAMPLE_W   = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 reverse,
    input  logic                 loop,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic [ADDR_W-1:0]    end_addr,
    input  logic [DIV_W-1:0]     rate_count,
    flash_stream_player_if.master mem,
    output logic [SAMPLE_W-1:0]  audio_out,
    output logic                 sample_strobe,
    output logic                 playing,
    output logic                 done,
    output logic                 underrun
);
    localparam int LANES  = DATA_W / SAMPLE_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int FA_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = FA_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_M1  = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DRAIN} state_t;

    state_t              state, state_nxt;
    logic                armed, aborting, pend, rev_q, loop_q;
    logic [ADDR_W-1:0]   ptr, start_q, end_q;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FA_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [LANE_W-1:0]   lane;
    logic [DIV_W-1:0]    div;

    logic kill, tick, pop_word, at_bound, space_after_push;
    logic start_go, empty_start, fin, accept, push, wrap, adv;

    // Lane order is ascending for forward play and descending for reverse play.
    function automatic logic [SAMPLE_W-1:0] lane_sample(input logic [DATA_W-1:0] word,
                                                        input logic [LANE_W-1:0] idx,
                                                        input logic              rev);
        logic [LANE_W-1:0] sel;
        sel = rev ? (LAST_LANE - idx) : idx;
        return word[int'(sel)*SAMPLE_W +: SAMPLE_W];
    endfunction

    assign mem.flash_mem_read    = (state == ISSUE);
    assign mem.flash_mem_address = ptr;

    // Once abort is seen it stays in force until the FSM is back in IDLE.
    assign kill             = aborting || (!enable && state != IDLE);
    assign tick             = playing && !kill && (div >= rate_count) &&
                              !(state == DRAIN && count == '0);
    assign pop_word         = tick && (count != '0) && (lane == LAST_LANE);
    assign at_bound         = rev_q ? (ptr == start_q) : (ptr == end_q);
    assign space_after_push = pop_word || (count < DEPTH_M1);

    always_comb begin
        state_nxt   = state;
        start_go    = 1'b0;
        empty_start = 1'b0;
        fin         = 1'b0;
        accept      = 1'b0;
        push        = 1'b0;
        wrap        = 1'b0;
        adv         = 1'b0;
        case (state)
            IDLE: begin
                if (enable && armed) begin
                    if (start_addr > end_addr) begin
                        empty_start = 1'b1;
                    end else begin
                        start_go  = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!mem.flash_mem_waitrequest) begin
                    accept    = 1'b1;
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (pend) begin
                    if (mem.flash_mem_readdatavalid) begin
                        if (kill) begin
                            state_nxt = IDLE;
                        end else begin
                            push = 1'b1;
                            if (at_bound && !loop_q) begin
                                state_nxt = DRAIN;
                            end else begin
                                wrap      = at_bound;
                                adv       = !at_bound;
                                state_nxt = space_after_push ? ISSUE : WAIT_DATA;
                            end
                        end
                    end
                end else if (kill) begin
                    state_nxt = IDLE;
                end else if (count < DEPTH_C) begin
                    state_nxt = ISSUE;
                end
            end
            DRAIN: begin
                if (kill) begin
                    state_nxt = IDLE;
                end else if (count == '0) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            armed         <= 1'b1;
            aborting      <= 1'b0;
            pend          <= 1'b0;
            rev_q         <= 1'b0;
            loop_q        <= 1'b0;
            ptr           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            lane          <= '0;
            div           <= '0;
            audio_out     <= '0;
            sample_strobe <= 1'b0;
            playing       <= 1'b0;
            done          <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            state         <= state_nxt;
            done          <= empty_start || fin;
            sample_strobe <= 1'b0;
            underrun      <= 1'b0;

            if (!enable)                  armed <= 1'b1;
            else if (empty_start || fin)  armed <= 1'b0;

            if (state_nxt == IDLE)                  aborting <= 1'b0;
            else if (!enable && state != IDLE)      aborting <= 1'b1;

            if (accept)                                               pend <= 1'b1;
            else if (state == WAIT_DATA && mem.flash_mem_readdatavalid) pend <= 1'b0;

            if (start_go) begin
                rev_q  <= reverse;
                loop_q <= loop;
                ptr    <= reverse ? end_addr : start_addr;
            end else if (wrap) begin
                ptr <= rev_q ? end_q : start_q;
            end else if (adv) begin
                ptr <= rev_q ? (ptr - ADDR_W'(1)) : (ptr + ADDR_W'(1));
            end

            if (start_go || !playing || div >= rate_count) div <= '0;
            else                                           div <= div + DIV_W'(1);

            if (start_go)          playing <= 1'b1;
            else if (kill || fin)  playing <= 1'b0;

            // Abort flushes the FIFO and silences the output.
            if (kill) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                lane      <= '0;
                audio_out <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + FA_W'(1);
                if (tick) begin
                    if (count != '0) begin
                        audio_out     <= lane_sample(fifo_mem[rd_ptr], lane, rev_q);
                        sample_strobe <= 1'b1;
                        if (pop_word) begin
                            lane   <= '0;
                            rd_ptr <= rd_ptr + FA_W'(1);
                        end else begin
                            lane <= lane + LANE_W'(1);
                        end
                    end else begin
                        underrun <= 1'b1;
                    end
                end
                if (push && !pop_word)      count <= count + CNT_W'(1);
                else if (!push && pop_word) count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem.flash_mem_readdata;
        if (start_go) begin
            start_q <= start_addr;
            end_q   <= end_addr;
        end
    end
endmodule

// File: tb/tb_flash_stream_player.sv
// Directed bench for flash_stream_player: flash slave model plus sample scoreboard.
module tb_flash_stream_player;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int DIV_W  = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic              enable, reverse, loop_i, en16;
    logic [ADDR_W-1:0] start_addr, end_addr;
    logic [DIV_W-1:0]  rate_count;
    logic [7:0]        audio_out;
    logic              sample_strobe, playing, done, underrun;
    logic [15:0]       audio16;
    logic              strobe16, playing16, done16, underrun16;

    flash_stream_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus8 ();
    flash_stream_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus16 ();

    flash_stream_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(8), .DIV_W(DIV_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .reverse(reverse), .loop(loop_i),
        .start_addr(start_addr), .end_addr(end_addr), .rate_count(rate_count), .mem(bus8),
        .audio_out(audio_out), .sample_strobe(sample_strobe), .playing(playing),
        .done(done), .underrun(underrun)
    );

    flash_stream_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_W(16), .DIV_W(DIV_W), .FIFO_DEPTH(4)) dut16 (
        .clk(clk), .reset(reset), .enable(en16), .reverse(1'b0), .loop(1'b0),
        .start_addr(23'h20), .end_addr(23'h1F), .rate_count(16'd0), .mem(bus16),
        .audio_out(audio16), .sample_strobe(strobe16), .playing(playing16),
        .done(done16), .underrun(underrun16)
    );

    int applied = 0;
    int fails   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
        case (a)
            23'h10:  return 32'h44332211;
            23'h11:  return 32'h88776655;
            23'h05:  return 32'hDDCCBBAA;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // Flash slave model: waitrequest stall counter, fixed read latency, expected-address queue.
    int                lat = 2, lat_cnt = 0, stall_left = 0, reads = 0;
    logic [ADDR_W-1:0] lat_addr, prev_addr, fixed_addr;
    logic              prev_read = 1'b0, prev_wreq = 1'b0, fixed_en = 1'b0;
    logic [ADDR_W-1:0] addr_q[$];

    always @(negedge clk) begin
        if (prev_read && prev_wreq) begin
            check("read_held", {31'd0, bus8.flash_mem_read}, 32'd1);
            check("addr_held", {9'd0, bus8.flash_mem_address}, {9'd0, prev_addr});
        end
        bus8.flash_mem_readdatavalid = 1'b0;
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                bus8.flash_mem_readdatavalid = 1'b1;
                bus8.flash_mem_readdata      = word_at(lat_addr);
            end
        end
        bus8.flash_mem_waitrequest = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        if (bus8.flash_mem_read && !bus8.flash_mem_waitrequest) begin
            reads++;
            lat_cnt  = lat;
            lat_addr = bus8.flash_mem_address;
            if (addr_q.size() > 0)
                check("read_addr", {9'd0, bus8.flash_mem_address}, {9'd0, addr_q.pop_front()});
            else if (fixed_en)
                check("read_addr", {9'd0, bus8.flash_mem_address}, {9'd0, fixed_addr});
            else begin
                applied++;
                fails++;
                $display("FAIL unexpected_read: address 0x%0h", bus8.flash_mem_address);
            end
        end
        prev_read = bus8.flash_mem_read;
        prev_wreq = bus8.flash_mem_waitrequest;
        prev_addr = bus8.flash_mem_address;
    end

    // Scoreboard monitor: pops one expected sample per strobe.
    logic [7:0] exp_q[$];
    logic [7:0] exp_s;
    int strobes = 0, done_cnt = 0, under_cnt = 0, under_first = 0, last_strobe = -1;
    int done16_cnt = 0, reads16 = 0, play16_seen = 0;
    logic chk_int = 1'b0;

    always @(negedge clk) begin
        if (underrun) under_cnt++;
        if (done) done_cnt++;
        if (done16) done16_cnt++;
        if (bus16.flash_mem_read) reads16++;
        if (playing16) play16_seen++;
        if (sample_strobe) begin
            strobes++;
            if (strobes == 1) under_first = under_cnt;
            if (exp_q.size() == 0) begin
                applied++;
                fails++;
                $display("FAIL extra_strobe: got sample 0x%0h, none expected", audio_out);
            end else begin
                exp_s = exp_q.pop_front();
                check("sample", {24'd0, audio_out}, {24'd0, exp_s});
            end
            if (chk_int && last_strobe >= 0)
                check("strobe_period", cyc - last_strobe, {16'd0, rate_count} + 32'd1);
            last_strobe = cyc;
        end
    end

    logic [7:0] fwd_s[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] rev_s[8] = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0] lp_s[4]  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_play(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                              input logic rev, input logic lp, input logic [DIV_W-1:0] rc,
                              input int latency);
        start_addr = s; end_addr = e; reverse = rev; loop_i = lp; rate_count = rc; lat = latency;
        done_cnt = 0; reads = 0; strobes = 0; under_cnt = 0; last_strobe = -1;
        enable = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == 0) begin
            applied++;
            fails++;
            $display("FAIL %s: done not seen, got 0 pulses in %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic wait_strobes(input string name, input int target, input int budget);
        int k = 0;
        while (strobes < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (strobes < target) begin
            applied++;
            fails++;
            $display("FAIL %s: got %0d strobes, expected %0d", name, strobes, target);
        end
    endtask

    task automatic wait_reads(input string name, input int target, input int budget);
        int k = 0;
        while (reads < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (reads < target) begin
            applied++;
            fails++;
            $display("FAIL %s: got %0d reads, expected %0d", name, reads, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, %0d miscompares so far", fails);
        $fatal(1);
    end

    initial begin
        int rd_snap;
        enable = 1'b0; reverse = 1'b0; loop_i = 1'b0; en16 = 1'b0;
        start_addr = '0; end_addr = '0; rate_count = '0;
        bus8.flash_mem_waitrequest = 1'b0; bus8.flash_mem_readdata = '0; bus8.flash_mem_readdatavalid = 1'b0;
        bus16.flash_mem_waitrequest = 1'b0; bus16.flash_mem_readdata = '0; bus16.flash_mem_readdatavalid = 1'b0;

        tick(3);
        check("rst_read", {31'd0, bus8.flash_mem_read}, 32'd0);
        check("rst_address", {9'd0, bus8.flash_mem_address}, 32'd0);
        check("rst_audio", {24'd0, audio_out}, 32'd0);
        check("rst_strobe", {31'd0, sample_strobe}, 32'd0);
        check("rst_playing", {31'd0, playing}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        reset = 1'b1;
        tick(2);

        // 16-bit instance with start > end: single done, no reads, never playing.
        en16 = 1'b1;
        @(negedge clk);
        check("t6_done_pulse", {31'd0, done16}, 32'd1);
        check("t6_playing", {31'd0, playing16}, 32'd0);
        @(negedge clk);
        check("t6_done_single", {31'd0, done16}, 32'd0);
        tick(10);
        check("t6_done_count", done16_cnt, 32'd1);
        check("t6_reads", reads16, 32'd0);
        check("t6_never_playing", play16_seen, 32'd0);
        en16 = 1'b0;

        // Forward single pass.
        foreach (fwd_s[i]) exp_q.push_back(fwd_s[i]);
        addr_q.push_back(23'h10); addr_q.push_back(23'h11);
        chk_int = 1'b1;
        start_play(23'h10, 23'h11, 1'b0, 1'b0, 16'd3, 2);
        wait_done("t1_done", 300);
        tick(20);
        check("t1_done_count", done_cnt, 32'd1);
        check("t1_reads", reads, 32'd2);
        check("t1_samples_left", exp_q.size(), 32'd0);
        check("t1_playing", {31'd0, playing}, 32'd0);
        check("t1_audio_hold", {24'd0, audio_out}, 32'h88);
        enable = 1'b0;
        tick(3);

        // Reverse single pass.
        foreach (rev_s[i]) exp_q.push_back(rev_s[i]);
        addr_q.push_back(23'h11); addr_q.push_back(23'h10);
        start_play(23'h10, 23'h11, 1'b1, 1'b0, 16'd3, 2);
        wait_done("t2_done", 300);
        tick(20);
        check("t2_done_count", done_cnt, 32'd1);
        check("t2_reads", reads, 32'd2);
        check("t2_samples_left", exp_q.size(), 32'd0);
        check("t2_audio_hold", {24'd0, audio_out}, 32'h11);
        enable = 1'b0;
        tick(3);

        // Long waitrequest stall with a tick every cycle.
        foreach (fwd_s[i]) exp_q.push_back(fwd_s[i]);
        addr_q.push_back(23'h10); addr_q.push_back(23'h11);
        chk_int = 1'b0;
        stall_left = 11;
        start_play(23'h10, 23'h11, 1'b0, 1'b0, 16'd0, 2);
        wait_done("t3_done", 300);
        tick(5);
        check("t3_underruns_before_data", {31'd0, under_first >= 10}, 32'd1);
        check("t3_reads", reads, 32'd2);
        check("t3_samples_left", exp_q.size(), 32'd0);
        check("t3_done_count", done_cnt, 32'd1);
        enable = 1'b0;
        tick(3);

        // Loop on a single word, then abort.
        for (int r = 0; r < 3; r++) foreach (lp_s[i]) exp_q.push_back(lp_s[i]);
        fixed_en = 1'b1; fixed_addr = 23'h05;
        chk_int = 1'b1;
        start_play(23'h05, 23'h05, 1'b0, 1'b1, 16'd1, 2);
        wait_strobes("t4_strobes", 12, 400);
        enable = 1'b0;
        tick(2);
        rd_snap = reads;
        tick(15);
        check("t4_no_read_after_abort", reads, rd_snap);
        check("t4_done_count", done_cnt, 32'd0);
        check("t4_playing", {31'd0, playing}, 32'd0);
        check("t4_audio_zero", {24'd0, audio_out}, 32'd0);
        check("t4_samples_left", exp_q.size(), 32'd0);
        fixed_en = 1'b0;
        chk_int = 1'b0;

        // Abort with a read outstanding, then replay.
        addr_q.push_back(23'h10);
        start_play(23'h10, 23'h11, 1'b0, 1'b0, 16'd3, 6);
        wait_reads("t5_first_read", 1, 30);
        tick(2);
        check("t5_playing_before_abort", {31'd0, playing}, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("t5_playing_after_abort", {31'd0, playing}, 32'd0);
        tick(14);
        check("t5_reads", reads, 32'd1);
        check("t5_done_count", done_cnt, 32'd0);
        check("t5_audio_zero", {24'd0, audio_out}, 32'd0);
        check("t5_strobes", strobes, 32'd0);
        foreach (fwd_s[i]) exp_q.push_back(fwd_s[i]);
        addr_q.push_back(23'h10); addr_q.push_back(23'h11);
        chk_int = 1'b1;
        start_play(23'h10, 23'h11, 1'b0, 1'b0, 16'd3, 2);
        wait_done("t5_replay_done", 300);
        tick(10);
        check("t5_replay_reads", reads, 32'd2);
        check("t5_replay_samples_left", exp_q.size(), 32'd0);
        check("t5_replay_audio", {24'd0, audio_out}, 32'h88);
        check("t5_replay_done_count", done_cnt, 32'd1);
        enable = 1'b0;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end
endmodule
